debug_trace_hub: RTL and testbench
==================================

// Module: debug_trace_hub
// PURPOSE
//  Debug-bus hub for the 5-stage RISC-V core. It replaces the combinational probe mux.
//  Probe words are packed on one parametrised bus. Read data is registered.
//  Adds a retired-PC trace ring, a PC breakpoint and a halt/step FSM. halt_req goes to the PCU.
//  Sits between the core/RF/IMU/DMU debug ports and the board-side debug bus (chk_addr/chk_data).
// PARAMETERS
//  NPROBE  96  number of 32-bit probe words on probe_bus, indexed 0..NPROBE-1 (NPROBE<=4096)
//  DEPTH   16  trace ring entries, power of two, 2..256
//  MAW     12  IMU/DMU debug address width
// PORTS
//  clk            in   1           core clock
//  rstn           in   1           synchronous reset, active low
//  chk_addr       in   16          debug address
//  chk_we         in   1           debug write strobe, only for control space 0x5xxx
//  chk_wdata      in   32          debug write data
//  chk_data       out  32          registered read data
//  chk_pc         out  32          PC of the last retired instruction
//  probe_bus      in   NPROBE*32   probe word k is bits [32k+31:32k]
//  wb_pc          in   32          WB-stage PC
//  wb_valid       in   1           an instruction retires this cycle
//  rf_debug_addr  out  5           chk_addr[4:0], combinational
//  rf_debug_data  in   32
//  imu_debug_addr out  MAW         chk_addr[MAW-1:0], combinational
//  imu_debug_data in   32
//  dmu_debug_addr out  MAW         chk_addr[MAW-1:0], combinational
//  dmu_debug_data in   32
//  halt_req       out  1           registered; PCU freezes pc_wen and all pipeline *_wen while it is 1
// BEHAVIOUR
//  Reset (rstn=0 at a clk edge) zeroes: chk_data, chk_pc, halt_req, bp_pc, ctrl, wr_ptr, count. FSM goes to RUN.
//  Reset mid-halt releases halt_req on the next edge. Ring contents are don't-care after reset.
//  Read path: one-cycle latency. chk_data at edge n+1 = f(chk_addr sampled at edge n).
//   0x0kkk -> probe word k when k<NPROBE, else 0.
//   0x1xxx -> rf_debug_data.
//   0x2xxx -> imu_debug_data.
//   0x3xxx -> dmu_debug_data.
//   0x4iii -> trace entry i, where i=0 is the oldest entry.
//      Value = ring[(wr_ptr-count+i) mod DEPTH] when i<count, else 0.
//   0x4FFF -> status {16'b0, count[7:0], 6'b0, state[1:0]}.
//   0x5000 -> bp_pc.
//   0x5001 -> ctrl {29'b0, trace_en, bp_en, 1'b0}.
//   Any other address -> 0.
//  Writes (chk_we=1), applied at the edge:
//   0x5000: bp_pc <= chk_wdata. Bits [1:0] are forced to 0.
//   0x5001: bp_en <= wdata[1]; trace_en <= wdata[2].
//      wdata[3] = clear trace: count<=0, wr_ptr<=0.
//      wdata[4] = resume. wdata[5] = step.
//      Bits 3..5 are self-clearing pulses.
//   Writes to other addresses are ignored.
//  Trace: on wb_valid && trace_en, ring[wr_ptr]<=wb_pc and wr_ptr<=wr_ptr+1 mod DEPTH.
//   count saturates at DEPTH. When full, the oldest entry is overwritten.
//   Clear and a retire in the same cycle: clear wins and the retire is not recorded.
//  chk_pc <= wb_pc on every wb_valid, regardless of trace_en.
//  FSM (state encoding: RUN=0, HALTED=1, STEP=2):
//   RUN: wb_valid && bp_en && wb_pc==bp_pc -> HALTED. halt_req=1 from the next cycle.
//      The matching instruction is retired and traced.
//   HALTED: halt_req=1.
//      resume -> RUN_SKIP, modelled as RUN with skip_flag=1. skip_flag suppresses the match for the first retire only.
//      step -> STEP. Resume and step together: step wins.
//   STEP: halt_req=0. The next wb_valid -> HALTED. That retire is not checked against bp.
//  A debug read never changes state, except that the combinational *_debug_addr outputs follow chk_addr.
//  Widths: pointers are clog2(DEPTH) bits; count is clog2(DEPTH)+1 bits. Index i uses chk_addr[7:0].
// STRUCTURE
//  Package dbg_pkg: address-space nibbles (DBG_PROBE=0 .. DBG_CTRL=5), ctrl bit indices, state enum {RUN,HALTED,STEP}.
//  Sub-module dbg_trace_ring (DEPTH, W=32): write port, clear, count, oldest-relative read index.
//  The hub holds the read mux, control registers and FSM.
// TESTING
//  1. NPROBE=96, probe word 5=0xDEAD0005, chk_addr=0x0005 -> chk_data=0xDEAD0005 one cycle later.
//     chk_addr=0x0060 -> 0.
//  2. trace_en=1, retire PCs 0x0,0x4,..,0x4C (20 retires, DEPTH=16) -> count=16.
//     0x4000 reads 0x10; 0x400F reads 0x4C; 0x4010 reads 0.
//  3. bp_pc=0x0000_0020, bp_en=1, run sequential code -> halt_req=1 the cycle after the WB of 0x20.
//     chk_pc=0x20; state=HALTED in status.
//  4. While HALTED write step -> halt_req=0 until one retire (0x24), then 1 again.
//     Then resume -> runs past 0x20 in a loop without re-halting on the first retire only.
//  5. Write clear in the same cycle as a retire -> count=0. 0x4000 reads 0.
//  6. rstn=0 for one edge while HALTED with count=5 -> halt_req=0, count=0, chk_data=0, bp_en=0 after that edge.

Source files
------------

// File: rtl/dbg_pkg.sv
// Shared address map, control-bit indices and FSM state type for the debug trace hub.
package dbg_pkg;

   localparam logic [3:0] DBG_PROBE = 4'h0;
   localparam logic [3:0] DBG_RF    = 4'h1;
   localparam logic [3:0] DBG_IMU   = 4'h2;
   localparam logic [3:0] DBG_DMU   = 4'h3;
   localparam logic [3:0] DBG_TRACE = 4'h4;
   localparam logic [3:0] DBG_CTRL  = 4'h5;

   localparam logic [11:0] TRACE_STATUS = 12'hFFF;
   localparam logic [11:0] CTRL_BP_PC   = 12'h000;
   localparam logic [11:0] CTRL_REG     = 12'h001;

   localparam int unsigned CTRL_BP_EN    = 1;
   localparam int unsigned CTRL_TRACE_EN = 2;
   localparam int unsigned CTRL_CLEAR    = 3;
   localparam int unsigned CTRL_RESUME   = 4;
   localparam int unsigned CTRL_STEP     = 5;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      HALTED = 2'd1,
      STEP   = 2'd2
   } dbg_state_e;

endpackage

// File: rtl/dbg_trace_ring.sv
// Retired-PC trace ring: overwrite-oldest write port, saturating count,
// read indexed relative to the oldest valid entry.
module dbg_trace_ring #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned W     = 32
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     clr,
   input  logic                     wr_en,
   input  logic [W-1:0]             wr_data,
   input  logic [7:0]               rd_idx,
   output logic [W-1:0]             rd_data_c,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   // Clear has priority over a same-cycle write.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr <= '0;
         count  <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         count  <= '0;
      end else if (wr_en) begin
         wr_ptr <= wr_ptr + PW'(1);
         if (count != CW'(DEPTH)) count <= count + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en && !clr) mem[wr_ptr] <= wr_data;
   end

   // Oldest entry sits at wr_ptr - count; pointer arithmetic wraps naturally.
   always_comb begin
      rd_ptr    = wr_ptr - PW'(count) + PW'(rd_idx);
      rd_data_c = '0;
      if (9'(rd_idx) < 9'(count)) rd_data_c = mem[rd_ptr];
   end

endmodule

// File: rtl/debug_trace_hub.sv
// Debug-bus hub: registered probe/RF/IMU/DMU/trace read mux, breakpoint and
// halt/step control for the core's PCU.
module debug_trace_hub
   import dbg_pkg::*;
#(
   parameter int unsigned NPROBE = 96,
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned MAW    = 12
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [15:0]          chk_addr,
   input  logic                 chk_we,
   input  logic [31:0]          chk_wdata,
   output logic [31:0]          chk_data,
   output logic [31:0]          chk_pc,
   input  logic [NPROBE*32-1:0] probe_bus,
   input  logic [31:0]          wb_pc,
   input  logic                 wb_valid,
   output logic [4:0]           rf_debug_addr,
   input  logic [31:0]          rf_debug_data,
   output logic [MAW-1:0]       imu_debug_addr,
   input  logic [31:0]          imu_debug_data,
   output logic [MAW-1:0]       dmu_debug_addr,
   input  logic [31:0]          dmu_debug_data,
   output logic                 halt_req
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   dbg_state_e    state, state_n;
   logic          skip, skip_n;
   logic [31:0]   bp_pc;
   logic          bp_en, trace_en;
   logic [CW-1:0] count;
   logic [31:0]   ring_data_c, probe_c, rd_mux_c;
   logic [3:0]    space_c;
   logic [11:0]   offset_c;
   logic          ctrl_wr_c, bp_wr_c, clr_c, resume_c, step_c, bp_hit_c;
   logic          unused_c;

   assign rf_debug_addr  = chk_addr[4:0];
   assign imu_debug_addr = chk_addr[MAW-1:0];
   assign dmu_debug_addr = chk_addr[MAW-1:0];

   assign space_c   = chk_addr[15:12];
   assign offset_c  = chk_addr[11:0];
   assign ctrl_wr_c = chk_we && (space_c == DBG_CTRL) && (offset_c == CTRL_REG);
   assign bp_wr_c   = chk_we && (space_c == DBG_CTRL) && (offset_c == CTRL_BP_PC);
   assign clr_c     = ctrl_wr_c && chk_wdata[CTRL_CLEAR];
   assign resume_c  = ctrl_wr_c && chk_wdata[CTRL_RESUME];
   assign step_c    = ctrl_wr_c && chk_wdata[CTRL_STEP];
   assign bp_hit_c  = wb_valid && bp_en && (wb_pc == bp_pc);
   assign unused_c  = chk_wdata[0];

   dbg_trace_ring #(.DEPTH(DEPTH), .W(32)) u_ring (
      .clk       (clk),
      .rstn      (rstn),
      .clr       (clr_c),
      .wr_en     (wb_valid && trace_en),
      .wr_data   (wb_pc),
      .rd_idx    (chk_addr[7:0]),
      .rd_data_c (ring_data_c),
      .count     (count)
   );

   // Probe select: out-of-range indices read as zero.
   always_comb begin
      probe_c = '0;
      for (int k = 0; k < NPROBE; k++) begin
         if (offset_c == 12'(k)) probe_c = probe_bus[32*k +: 32];
      end
   end

   always_comb begin
      rd_mux_c = '0;
      case (space_c)
         DBG_PROBE: rd_mux_c = probe_c;
         DBG_RF:    rd_mux_c = rf_debug_data;
         DBG_IMU:   rd_mux_c = imu_debug_data;
         DBG_DMU:   rd_mux_c = dmu_debug_data;
         DBG_TRACE: begin
            if (offset_c == TRACE_STATUS) rd_mux_c = {16'b0, 8'(count), 6'b0, state};
            else                          rd_mux_c = ring_data_c;
         end
         DBG_CTRL: begin
            if (offset_c == CTRL_BP_PC)    rd_mux_c = bp_pc;
            else if (offset_c == CTRL_REG) rd_mux_c = {29'b0, trace_en, bp_en, 1'b0};
         end
         default: rd_mux_c = '0;
      endcase
   end

   // skip is set on resume so the instruction sitting on the breakpoint can retire.
   always_comb begin
      state_n = state;
      skip_n  = skip;
      case (state)
         RUN: begin
            if (wb_valid) skip_n = 1'b0;
            if (bp_hit_c && !skip) state_n = HALTED;
         end
         HALTED: begin
            if (step_c) begin
               state_n = STEP;
            end else if (resume_c) begin
               state_n = RUN;
               skip_n  = 1'b1;
            end
         end
         STEP: begin
            if (wb_valid) state_n = HALTED;
         end
         default: state_n = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state    <= RUN;
         skip     <= 1'b0;
         halt_req <= 1'b0;
      end else begin
         state    <= state_n;
         skip     <= skip_n;
         halt_req <= (state_n == HALTED);
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         chk_data <= '0;
         chk_pc   <= '0;
         bp_pc    <= '0;
         bp_en    <= 1'b0;
         trace_en <= 1'b0;
      end else begin
         chk_data <= rd_mux_c;
         if (wb_valid) chk_pc <= wb_pc;
         if (bp_wr_c) bp_pc <= {chk_wdata[31:2], 2'b00};
         if (ctrl_wr_c) begin
            bp_en    <= chk_wdata[CTRL_BP_EN];
            trace_en <= chk_wdata[CTRL_TRACE_EN];
         end
      end
   end

endmodule

// File: tb/tb_debug_trace_hub.sv
// Self-checking bench for debug_trace_hub: read scoreboard plus inline
// checks of halt_req/chk_pc across breakpoint, step, resume, clear and reset.
module tb_debug_trace_hub;

   localparam int unsigned NPROBE = 96;
   localparam int unsigned DEPTH  = 16;
   localparam int unsigned MAW    = 12;

   logic                 clk = 1'b0;
   logic                 rstn;
   logic [15:0]          chk_addr;
   logic                 chk_we;
   logic [31:0]          chk_wdata;
   logic [31:0]          chk_data;
   logic [31:0]          chk_pc;
   logic [NPROBE*32-1:0] probe_bus;
   logic [31:0]          wb_pc;
   logic                 wb_valid;
   logic [4:0]           rf_debug_addr;
   logic [31:0]          rf_debug_data;
   logic [MAW-1:0]       imu_debug_addr;
   logic [31:0]          imu_debug_data;
   logic [MAW-1:0]       dmu_debug_addr;
   logic [31:0]          dmu_debug_data;
   logic                 halt_req;

   debug_trace_hub #(.NPROBE(NPROBE), .DEPTH(DEPTH), .MAW(MAW)) dut (
      .clk            (clk),
      .rstn           (rstn),
      .chk_addr       (chk_addr),
      .chk_we         (chk_we),
      .chk_wdata      (chk_wdata),
      .chk_data       (chk_data),
      .chk_pc         (chk_pc),
      .probe_bus      (probe_bus),
      .wb_pc          (wb_pc),
      .wb_valid       (wb_valid),
      .rf_debug_addr  (rf_debug_addr),
      .rf_debug_data  (rf_debug_data),
      .imu_debug_addr (imu_debug_addr),
      .imu_debug_data (imu_debug_data),
      .dmu_debug_addr (dmu_debug_addr),
      .dmu_debug_data (dmu_debug_data),
      .halt_req       (halt_req)
   );

   always #5 clk = ~clk;

   // Memory models answer from the address the hub presents.
   assign rf_debug_data  = 32'h0F00_0000 | {27'b0, rf_debug_addr};
   assign imu_debug_data = 32'h1A00_0000 | {20'b0, imu_debug_addr};
   assign dmu_debug_data = 32'h2D00_0000 | {20'b0, dmu_debug_addr};

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];
   string       name_q[$];
   logic [31:0] tq[$];
   logic        trace_en_m = 1'b0;

   task automatic cycle(input logic we, input logic [15:0] addr, input logic [31:0] wdata,
                        input logic wv, input logic [31:0] pc);
      @(negedge clk);
      chk_we    = we;
      chk_addr  = addr;
      chk_wdata = wdata;
      wb_valid  = wv;
      wb_pc     = pc;
      if (we && addr == 16'h5001 && wdata[3]) begin
         tq.delete();
      end else if (wv && trace_en_m) begin
         tq.push_back(pc);
         if (tq.size() > DEPTH) void'(tq.pop_front());
      end
      if (we && addr == 16'h5001) trace_en_m = wdata[2];
      @(posedge clk);
      #1;
      chk_we   = 1'b0;
      wb_valid = 1'b0;
   endtask

   task automatic retire(input logic [31:0] pc);
      cycle(1'b0, 16'h0000, 32'h0, 1'b1, pc);
   endtask

   task automatic ctrl_write(input logic [15:0] addr, input logic [31:0] data);
      cycle(1'b1, addr, data, 1'b0, 32'h0);
   endtask

   // Scoreboard: expectation queued with the address, retired when chk_data updates.
   task automatic read_check(input logic [15:0] addr, input logic [31:0] exp, input string name);
      logic [31:0] e;
      string       n;
      @(negedge clk);
      chk_addr = addr;
      exp_q.push_back(exp);
      name_q.push_back(name);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if (chk_data !== e) begin
         errors++;
         $display("FAIL %s: chk_data=%h expected %h", n, chk_data, e);
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      chk_addr = 16'h0005;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (chk_data !== 32'h0) begin errors++; $display("FAIL reset_chk_data: got %h expected 0", chk_data); end
      checks++;
      if (chk_pc !== 32'h0) begin errors++; $display("FAIL reset_chk_pc: got %h expected 0", chk_pc); end
      checks++;
      if (halt_req !== 1'b0) begin errors++; $display("FAIL reset_halt: got %b expected 0", halt_req); end
      @(negedge clk);
      rstn = 1'b1;
      read_check(16'h4FFF, 32'h0, "reset_status");
      read_check(16'h5001, 32'h0, "reset_ctrl");
      read_check(16'h5000, 32'h0, "reset_bp_pc");
   endtask

   task automatic test_probe();
      read_check(16'h0005, 32'hDEAD_0005, "probe_5");
      read_check(16'h0000, 32'hDEAD_0000, "probe_0");
      read_check(16'h005F, 32'hDEAD_005F, "probe_last");
      read_check(16'h0060, 32'h0, "probe_oob");
      read_check(16'h0FFF, 32'h0, "probe_oob_max");
      read_check(16'h1003, 32'h0F00_0003, "rf_read");
      read_check(16'h2ABC, 32'h1A00_0ABC, "imu_read");
      read_check(16'h3123, 32'h2D00_0123, "dmu_read");
      read_check(16'h6000, 32'h0, "unmapped");
      read_check(16'h5002, 32'h0, "ctrl_hole");
   endtask

   task automatic test_trace_wrap();
      retire(32'h100);
      checks++;
      if (chk_pc !== 32'h100) begin errors++; $display("FAIL pc_no_trace: got %h expected 100", chk_pc); end
      read_check(16'h4FFF, 32'h0, "status_trace_off");
      ctrl_write(16'h5001, 32'h4);
      for (int i = 0; i < 20; i++) retire(32'(i * 4));
      checks++;
      if (chk_pc !== 32'h4C) begin errors++; $display("FAIL pc_wrap: got %h expected 4c", chk_pc); end
      read_check(16'h4FFF, {16'b0, 8'(tq.size()), 8'h00}, "status_full");
      read_check(16'h4FFF, 32'h0000_1000, "status_full_const");
      read_check(16'h4000, 32'h10, "trace_oldest");
      read_check(16'h400F, 32'h4C, "trace_newest");
      read_check(16'h4010, 32'h0, "trace_beyond");
      for (int i = 0; i < 16; i++) read_check(16'h4000 + 16'(i), tq[i], $sformatf("trace_%0d", i));
   endtask

   task automatic test_breakpoint();
      ctrl_write(16'h5001, 32'hE);
      ctrl_write(16'h5000, 32'h23);
      read_check(16'h5000, 32'h20, "bp_pc_align");
      read_check(16'h5001, 32'h6, "ctrl_readback");
      for (int pc = 0; pc < 32'h20; pc += 4) begin
         retire(32'(pc));
         checks++;
         if (halt_req !== 1'b0) begin errors++; $display("FAIL early_halt pc=%h: got %b expected 0", pc, halt_req); end
      end
      retire(32'h20);
      checks++;
      if (halt_req !== 1'b1) begin errors++; $display("FAIL bp_halt: got %b expected 1", halt_req); end
      checks++;
      if (chk_pc !== 32'h20) begin errors++; $display("FAIL bp_chk_pc: got %h expected 20", chk_pc); end
      read_check(16'h4FFF, 32'h0000_0901, "status_halted");
      read_check(16'h4008, 32'h20, "bp_instr_traced");
      checks++;
      if (halt_req !== 1'b1) begin errors++; $display("FAIL halt_hold: got %b expected 1", halt_req); end
   endtask

   task automatic test_step_resume();
      ctrl_write(16'h5001, 32'h26);
      checks++;
      if (halt_req !== 1'b0) begin errors++; $display("FAIL step_release: got %b expected 0", halt_req); end
      read_check(16'h4FFF, 32'h0000_0902, "status_step");
      checks++;
      if (halt_req !== 1'b0) begin errors++; $display("FAIL step_hold: got %b expected 0", halt_req); end
      retire(32'h24);
      checks++;
      if (halt_req !== 1'b1) begin errors++; $display("FAIL step_rehalt: got %b expected 1", halt_req); end
      checks++;
      if (chk_pc !== 32'h24) begin errors++; $display("FAIL step_chk_pc: got %h expected 24", chk_pc); end
      read_check(16'h4FFF, 32'h0000_0A01, "status_after_step");
      ctrl_write(16'h5001, 32'h36);
      read_check(16'h4FFF, 32'h0000_0A02, "step_beats_resume");
      retire(32'h28);
      checks++;
      if (halt_req !== 1'b1) begin errors++; $display("FAIL step2_rehalt: got %b expected 1", halt_req); end
      ctrl_write(16'h5001, 32'h16);
      checks++;
      if (halt_req !== 1'b0) begin errors++; $display("FAIL resume_release: got %b expected 0", halt_req); end
      read_check(16'h4FFF, 32'h0000_0B00, "status_resumed");
      retire(32'h20);
      checks++;
      if (halt_req !== 1'b0) begin errors++; $display("FAIL skip_first: got %b expected 0", halt_req); end
      retire(32'h24);
      retire(32'h28);
      checks++;
      if (halt_req !== 1'b0) begin errors++; $display("FAIL loop_run: got %b expected 0", halt_req); end
      retire(32'h20);
      checks++;
      if (halt_req !== 1'b1) begin errors++; $display("FAIL loop_rehalt: got %b expected 1", halt_req); end
      read_check(16'h4FFF, {16'b0, 8'(tq.size()), 8'h01}, "status_loop");
   endtask

   task automatic test_clear_retire();
      ctrl_write(16'h5001, 32'h14);
      checks++;
      if (halt_req !== 1'b0) begin errors++; $display("FAIL resume2: got %b expected 0", halt_req); end
      cycle(1'b1, 16'h5001, 32'h0C, 1'b1, 32'h80);
      checks++;
      if (chk_pc !== 32'h80) begin errors++; $display("FAIL clear_chk_pc: got %h expected 80", chk_pc); end
      read_check(16'h4FFF, 32'h0, "clear_status");
      read_check(16'h4000, 32'h0, "clear_entry0");
      retire(32'h84);
      read_check(16'h4000, tq[0], "after_clear_entry0");
      read_check(16'h4FFF, 32'h0000_0100, "after_clear_status");
   endtask

   task automatic test_reset_halted();
      ctrl_write(16'h5001, 32'hE);
      ctrl_write(16'h5000, 32'h200);
      for (int i = 0; i < 5; i++) retire(32'h1F0 + 32'(i * 4));
      checks++;
      if (halt_req !== 1'b1) begin errors++; $display("FAIL pre_reset_halt: got %b expected 1", halt_req); end
      read_check(16'h4FFF, 32'h0000_0501, "pre_reset_status");
      @(negedge clk);
      rstn = 1'b0;
      chk_addr = 16'h0005;
      @(posedge clk);
      #1;
      checks++;
      if (halt_req !== 1'b0) begin errors++; $display("FAIL rst_halt: got %b expected 0", halt_req); end
      checks++;
      if (chk_data !== 32'h0) begin errors++; $display("FAIL rst_chk_data: got %h expected 0", chk_data); end
      checks++;
      if (chk_pc !== 32'h0) begin errors++; $display("FAIL rst_chk_pc: got %h expected 0", chk_pc); end
      @(negedge clk);
      rstn = 1'b1;
      tq.delete();
      trace_en_m = 1'b0;
      read_check(16'h4FFF, 32'h0, "rst_status");
      read_check(16'h5001, 32'h0, "rst_ctrl");
      read_check(16'h5000, 32'h0, "rst_bp_pc");
      retire(32'h200);
      checks++;
      if (halt_req !== 1'b0) begin errors++; $display("FAIL rst_bp_disabled: got %b expected 0", halt_req); end
      checks++;
      if (chk_pc !== 32'h200) begin errors++; $display("FAIL rst_chk_pc_after: got %h expected 200", chk_pc); end
   endtask

   initial begin
      rstn      = 1'b0;
      chk_addr  = 16'h0;
      chk_we    = 1'b0;
      chk_wdata = 32'h0;
      wb_pc     = 32'h0;
      wb_valid  = 1'b0;
      for (int k = 0; k < NPROBE; k++) probe_bus[32*k +: 32] = 32'hDEAD_0000 | 32'(k);
      test_reset();
      test_probe();
      test_trace_wrap();
      test_breakpoint();
      test_step_resume();
      test_clear_retire();
      test_reset_halted();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
